ram_port_arbiter: RTL and testbench

- Shares one simple dual-port RAM (one write port A, one registered read port B, 1-cycle read latency) between two training-datapath clients.
- Each client issues independent write and read requests.
- Two independent 2-way round-robin arbiters grant port A and port B.
- The block tags each granted read and routes the RAM output back to the issuing client one cycle later.

---
 rtl/ram_port_arbiter_pkg.sv | 18 +
 rtl/ram_port_arbiter_if.sv | 47 ++++
 rtl/ram_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 86 ++++++++
 tb/tb_ram_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: default RAM geometry,
// client index constants and the round-robin priority encoding.
// Optional build macro used by this slice: RAM_RAW_BYPASS_EN.
package ram_port_arbiter_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 32;

    localparam int CLIENT0 = 0;
    localparam int CLIENT1 = 1;

    // Which client wins when both request in the same cycle.
    typedef enum logic {
        PRIO_C0 = 1'b0,
        PRIO_C1 = 1'b1
    } prio_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of client request/response signals and the RAM-side port signals.
// slave is the arbiter's view; master is the view of whatever sits around it
// (the clients plus the RAM itself).
interface ram_port_arbiter_if #(
    parameter int addrLen = ram_port_arbiter_pkg::RAM_ADDR_W,
    parameter int dataLen = ram_port_arbiter_pkg::RAM_DATA_W
) ();

    logic [1:0]         wr_valid;
    logic [addrLen-1:0] wr_addr0;
    logic [addrLen-1:0] wr_addr1;
    logic [dataLen-1:0] wr_data0;
    logic [dataLen-1:0] wr_data1;
    logic [1:0]         wr_ready;

    logic [1:0]         rd_valid;
    logic [addrLen-1:0] rd_addr0;
    logic [addrLen-1:0] rd_addr1;
    logic [1:0]         rd_ready;

    logic [1:0]         rsp_valid;
    logic [dataLen-1:0] rsp_data;

    logic               ram_we_a;
    logic [addrLen-1:0] ram_addr_a;
    logic [dataLen-1:0] ram_data_a;
    logic               ram_re_b;
    logic [addrLen-1:0] ram_addr_b;
    logic [dataLen-1:0] ram_q_b;

    modport slave (
        input  wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_valid, rd_addr0, rd_addr1,
        input  ram_q_b,
        output wr_ready, rd_ready, rsp_valid, rsp_data,
        output ram_we_a, ram_addr_a, ram_data_a, ram_re_b, ram_addr_b
    );

    modport master (
        output wr_valid, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_valid, rd_addr0, rd_addr1,
        output ram_q_b,
        input  wr_ready, rd_ready, rsp_valid, rsp_data,
        input  ram_we_a, ram_addr_a, ram_data_a, ram_re_b, ram_addr_b
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// and the priority register; after any grant the loser of that grant gets
// priority next time. Reset holds the grant low.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import ram_port_arbiter_pkg::*;

    prio_e prio_reg;
    prio_e prio_next;

    // Grant selection and priority update; idle cycles leave priority alone.
    always_comb begin
        gnt       = 2'b00;
        prio_next = prio_reg;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio_reg == PRIO_C1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt != 2'b00) begin
            prio_next = gnt[CLIENT1] ? PRIO_C0 : PRIO_C1;
        end
    end

    // Priority register, client 0 favoured out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= PRIO_C0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a simple dual-port RAM (write port A, registered read port B)
// between two clients. Independent round-robin arbiters grant each port; the
// read grant is registered so the response lands on the issuing client one
// cycle later, with the RAM output passed straight through.
// Build macro RAM_RAW_BYPASS_EN: forwards same-cycle write data to a read of
// the same address (write-first); without it the RAM's read-first data is
// returned.
module ram_port_arbiter #(
    parameter int addrLen = ram_port_arbiter_pkg::RAM_ADDR_W,
    parameter int dataLen = ram_port_arbiter_pkg::RAM_DATA_W
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);
    import ram_port_arbiter_pkg::*;

    // Index 0 is the write port arbiter, index 1 the read port arbiter.
    logic [1:0][1:0] req_v;
    logic [1:0][1:0] gnt_v;

    logic [addrLen-1:0] wr_addr_sel;
    logic [dataLen-1:0] wr_data_sel;
    logic [addrLen-1:0] rd_addr_sel;
    logic [1:0]         rsp_valid_reg;

    assign req_v[0] = bus.wr_valid;
    assign req_v[1] = bus.rd_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            rr_arb2 u_arb (
                .clk (clk),
                .rst (rst),
                .req (req_v[gi]),
                .gnt (gnt_v[gi])
            );
        end
    endgenerate

    assign bus.wr_ready = gnt_v[0];
    assign bus.rd_ready = gnt_v[1];

    // Port muxes fall back to client 0 when nothing is granted.
    assign wr_addr_sel = gnt_v[0][CLIENT1] ? bus.wr_addr1 : bus.wr_addr0;
    assign wr_data_sel = gnt_v[0][CLIENT1] ? bus.wr_data1 : bus.wr_data0;
    assign rd_addr_sel = gnt_v[1][CLIENT1] ? bus.rd_addr1 : bus.rd_addr0;

    assign bus.ram_we_a   = |gnt_v[0];
    assign bus.ram_addr_a = wr_addr_sel;
    assign bus.ram_data_a = wr_data_sel;
    assign bus.ram_re_b   = |gnt_v[1];
    assign bus.ram_addr_b = rd_addr_sel;

    // Response tag: which client's read the RAM is returning this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_reg <= 2'b00;
        end else begin
            rsp_valid_reg <= gnt_v[1];
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;

`ifdef RAM_RAW_BYPASS_EN
    logic               byp_reg;
    logic [dataLen-1:0] byp_data_reg;

    // Capture write data when it collides with a granted read of the same address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_reg      <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            byp_reg      <= bus.ram_we_a && bus.ram_re_b && (wr_addr_sel == rd_addr_sel);
            byp_data_reg <= wr_data_sel;
        end
    end

    assign bus.rsp_data = byp_reg ? byp_data_reg : bus.ram_q_b;
`else
    assign bus.rsp_data = bus.ram_q_b;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM with registered read, a shadow
// memory for expected contents, and a response scoreboard keyed by the cycle
// on which each response is due.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if bus ();

    ram_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: read-first, one-cycle registered read.
    logic [31:0] mem [64];
    logic [31:0] q_reg;
    always @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
        if (bus.ram_re_b) q_reg <= mem[bus.ram_addr_b];
    end
    assign bus.ram_q_b = q_reg;

    typedef struct {
        int          due;
        logic [1:0]  client;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    rsp_t        cur_rsp;
    logic [31:0] shadow [64];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          chk_on   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response checker: either the scheduled response or silence each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                cur_rsp = sb.pop_front();
                n_checks++;
                if (bus.rsp_valid !== cur_rsp.client || bus.rsp_data !== cur_rsp.data)
                    $display("FAIL rsp cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                             cyc, bus.rsp_valid, bus.rsp_data, cur_rsp.client, cur_rsp.data);
                else begin
                    n_pass++;
                    $display("rsp cyc=%0d client=%b data=%h", cyc, bus.rsp_valid, bus.rsp_data);
                end
            end else begin
                n_checks++;
                if (bus.rsp_valid !== 2'b00)
                    $display("FAIL rsp_idle cyc=%0d got valid=%b want 00", cyc, bus.rsp_valid);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_wr(input logic [1:0] v, input logic [5:0] a0, input logic [31:0] d0,
                          input logic [5:0] a1, input logic [31:0] d1);
        bus.wr_valid = v;
        bus.wr_addr0 = a0;
        bus.wr_data0 = d0;
        bus.wr_addr1 = a1;
        bus.wr_data1 = d1;
    endtask

    task automatic set_rd(input logic [1:0] v, input logic [5:0] a0, input logic [5:0] a1);
        bus.rd_valid = v;
        bus.rd_addr0 = a0;
        bus.rd_addr1 = a1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        set_wr(2'b11, 1, 32'h1, 2, 32'h2);
        set_rd(2'b11, 1, 2);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b00 || bus.rd_ready !== 2'b00 || bus.ram_we_a !== 1'b0 ||
            bus.ram_re_b !== 1'b0 || bus.rsp_valid !== 2'b00)
            $display("FAIL reset_outputs got wr=%b rd=%b we=%b re=%b rsp=%b want all 0",
                     bus.wr_ready, bus.rd_ready, bus.ram_we_a, bus.ram_re_b, bus.rsp_valid);
        else n_pass++;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b00, 0, 0);
        rst = 1'b0;
        chk_on = 1'b1;
        $display("reset released cyc=%0d", cyc);
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        set_wr(2'b01, 5, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b01 || bus.ram_we_a !== 1'b1 || bus.ram_addr_a !== 6'd5 ||
            bus.ram_data_a !== 32'hDEADBEEF || bus.rd_ready !== 2'b00)
            $display("FAIL basic_write got rdy=%b we=%b addr=%0d data=%h want 01 1 5 deadbeef",
                     bus.wr_ready, bus.ram_we_a, bus.ram_addr_a, bus.ram_data_a);
        else n_pass++;
        shadow[5] = 32'hDEADBEEF;
        $display("write client=01 addr=5 data=deadbeef");
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b10, 0, 5);
        @(negedge clk);
        n_checks++;
        if (bus.rd_ready !== 2'b10 || bus.ram_re_b !== 1'b1 || bus.ram_addr_b !== 6'd5 ||
            bus.wr_ready !== 2'b00 || bus.ram_we_a !== 1'b0)
            $display("FAIL basic_read got rdy=%b re=%b addr=%0d wr=%b want 10 1 5 00",
                     bus.rd_ready, bus.ram_re_b, bus.ram_addr_b, bus.wr_ready);
        else n_pass++;
        sb.push_back('{due: cyc + 1, client: 2'b10, data: shadow[5]});
        @(posedge clk); #1;
        set_rd(2'b00, 0, 0);
    endtask

    task automatic test_write_alt();
        logic [1:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            set_wr(2'b11, 1, 32'h11, 2, 32'h22);
            @(negedge clk);
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (bus.wr_ready !== exp_g || bus.ram_we_a !== 1'b1 ||
                bus.ram_addr_a !== ((exp_g == 2'b01) ? 6'd1 : 6'd2) ||
                bus.ram_data_a !== ((exp_g == 2'b01) ? 32'h11 : 32'h22))
                $display("FAIL write_alt[%0d] got rdy=%b addr=%0d data=%h want rdy=%b",
                         i, bus.wr_ready, bus.ram_addr_a, bus.ram_data_a, exp_g);
            else n_pass++;
            $display("write client=%b addr=%0d data=%h", bus.wr_ready, bus.ram_addr_a, bus.ram_data_a);
        end
        shadow[1] = 32'h11;
        shadow[2] = 32'h22;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
    endtask

    task automatic test_read_alt();
        logic [1:0] exp_g;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            set_rd(2'b11, 1, 2);
            @(negedge clk);
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (bus.rd_ready !== exp_g || bus.ram_re_b !== 1'b1 ||
                bus.ram_addr_b !== ((exp_g == 2'b01) ? 6'd1 : 6'd2))
                $display("FAIL read_alt[%0d] got rdy=%b addr=%0d want rdy=%b",
                         i, bus.rd_ready, bus.ram_addr_b, exp_g);
            else n_pass++;
            sb.push_back('{due: cyc + 1, client: exp_g,
                           data: (exp_g == 2'b01) ? shadow[1] : shadow[2]});
        end
        @(posedge clk); #1;
        set_rd(2'b00, 0, 0);
    endtask

    task automatic test_raw();
        @(posedge clk); #1;
        set_wr(2'b01, 7, 32'h33, 0, 0);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b01 || bus.ram_addr_a !== 6'd7)
            $display("FAIL raw_preload got rdy=%b addr=%0d want 01 7", bus.wr_ready, bus.ram_addr_a);
        else n_pass++;
        shadow[7] = 32'h33;
        @(posedge clk); #1;
        set_wr(2'b01, 7, 32'h55, 0, 0);
        set_rd(2'b01, 7, 0);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b01 || bus.rd_ready !== 2'b01 ||
            bus.ram_addr_a !== 6'd7 || bus.ram_addr_b !== 6'd7)
            $display("FAIL raw_same_cycle got wr=%b rd=%b aa=%0d ab=%0d want 01 01 7 7",
                     bus.wr_ready, bus.rd_ready, bus.ram_addr_a, bus.ram_addr_b);
        else n_pass++;
`ifdef RAM_RAW_BYPASS_EN
        sb.push_back('{due: cyc + 1, client: 2'b01, data: 32'h55});
`else
        sb.push_back('{due: cyc + 1, client: 2'b01, data: shadow[7]});
`endif
        shadow[7] = 32'h55;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b01, 7, 0);
        @(negedge clk);
        n_checks++;
        if (bus.rd_ready !== 2'b01 || bus.ram_we_a !== 1'b0)
            $display("FAIL raw_reread got rd=%b we=%b want 01 0", bus.rd_ready, bus.ram_we_a);
        else n_pass++;
        sb.push_back('{due: cyc + 1, client: 2'b01, data: shadow[7]});
        @(posedge clk); #1;
        set_rd(2'b00, 0, 0);
    endtask

    task automatic test_idle();
        // Both priority registers point at client 1 after the single-client
        // grants above; idling must not disturb that.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            set_wr(2'b00, 0, 0, 0, 0);
            set_rd(2'b00, 0, 0);
            @(negedge clk);
            n_checks++;
            if (bus.wr_ready !== 2'b00 || bus.rd_ready !== 2'b00 ||
                bus.ram_we_a !== 1'b0 || bus.ram_re_b !== 1'b0)
                $display("FAIL idle[%0d] got wr=%b rd=%b we=%b re=%b want all 0",
                         i, bus.wr_ready, bus.rd_ready, bus.ram_we_a, bus.ram_re_b);
            else n_pass++;
        end
        @(posedge clk); #1;
        set_wr(2'b11, 8, 32'h88, 9, 32'h99);
        set_rd(2'b11, 5, 7);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b10 || bus.rd_ready !== 2'b10 || bus.ram_addr_a !== 6'd9 ||
            bus.ram_data_a !== 32'h99 || bus.ram_addr_b !== 6'd7)
            $display("FAIL idle_prio_hold got wr=%b rd=%b aa=%0d da=%h ab=%0d want 10 10 9 99 7",
                     bus.wr_ready, bus.rd_ready, bus.ram_addr_a, bus.ram_data_a, bus.ram_addr_b);
        else n_pass++;
        sb.push_back('{due: cyc + 1, client: 2'b10, data: shadow[7]});
        shadow[9] = 32'h99;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b00, 0, 0);
    endtask

    task automatic test_reset_mid();
        // A normal grant first moves both priorities to client 1.
        @(posedge clk); #1;
        set_wr(2'b01, 10, 32'hAA, 0, 0);
        set_rd(2'b01, 5, 0);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b01 || bus.rd_ready !== 2'b01)
            $display("FAIL mid_pre got wr=%b rd=%b want 01 01", bus.wr_ready, bus.rd_ready);
        else n_pass++;
        sb.push_back('{due: cyc + 1, client: 2'b01, data: shadow[5]});
        shadow[10] = 32'hAA;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b01, 5, 0);
        @(negedge clk);
        n_checks++;
        if (bus.rd_ready !== 2'b01)
            $display("FAIL mid_grant got rd=%b want 01", bus.rd_ready);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.rd_ready !== 2'b00 || bus.ram_re_b !== 1'b0 || bus.rsp_valid !== 2'b00)
            $display("FAIL mid_reset_force got rd=%b re=%b rsp=%b want 00 0 00",
                     bus.rd_ready, bus.ram_re_b, bus.rsp_valid);
        else n_pass++;
        set_rd(2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("mid-run reset released cyc=%0d", cyc);
        @(posedge clk); #1;
        set_wr(2'b11, 11, 32'hB0, 12, 32'hB1);
        set_rd(2'b11, 7, 5);
        @(negedge clk);
        n_checks++;
        if (bus.wr_ready !== 2'b01 || bus.rd_ready !== 2'b01 ||
            bus.ram_addr_a !== 6'd11 || bus.ram_addr_b !== 6'd7)
            $display("FAIL mid_prio_reset got wr=%b rd=%b aa=%0d ab=%0d want 01 01 11 7",
                     bus.wr_ready, bus.rd_ready, bus.ram_addr_a, bus.ram_addr_b);
        else n_pass++;
        sb.push_back('{due: cyc + 1, client: 2'b01, data: shadow[7]});
        shadow[11] = 32'hB0;
        @(posedge clk); #1;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(2'b00, 0, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_alt();
        test_read_alt();
        test_raw();
        test_idle();
        test_reset_mid();
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
